// File: rtl/while_inverse_pkg.sv
// Shared types and helpers for the while_inverse decoder.
// Provides the FSM state encoding and the multiplier derived from COUNT.
package while_inverse_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  // Multiplier used by the encoder; wraps to 0 when count is 255.
  function automatic logic [7:0] k_of(input int unsigned count);
    return 8'(count + 1);
  endfunction

endpackage

// File: rtl/while_inverse.sv
// Sequential inverse of XOUT = 8'(K*A) - B: walks candidates 0..255, one per clock,
// accumulating the product so no multiplier or divider is needed.
module while_inverse
  import while_inverse_pkg::*;
#(
  parameter int unsigned COUNT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [7:0] XOUT,
  input  logic [7:0] B,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] A_OUT,
  output logic       FOUND
);

  localparam logic [7:0] K = k_of(COUNT);

  state_e     state_q, state_d;
  logic [7:0] s_q, s_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] prod_q, prod_d;
  logic [7:0] a_q, a_d;
  logic       found_q, found_d;
  logic       prime_q, prime_d;
  logic       exhaust_q, exhaust_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      s_q       <= '0;
      cand_q    <= '0;
      prod_q    <= '0;
      a_q       <= '0;
      found_q   <= 1'b0;
      prime_q   <= 1'b0;
      exhaust_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cand_q    <= cand_d;
      prod_q    <= prod_d;
      a_q       <= a_d;
      found_q   <= found_d;
      prime_q   <= prime_d;
      exhaust_q <= exhaust_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cand_d    = cand_q;
    prod_d    = prod_q;
    a_d       = a_q;
    found_d   = found_q;
    prime_d   = prime_q;
    exhaust_d = exhaust_q;

    case (state_q)
      StIdle: begin
        if (IN_VALID) begin
          s_d       = XOUT + B;
          cand_d    = '0;
          prod_d    = '0;
          a_d       = '0;
          found_d   = 1'b0;
          prime_d   = 1'b1;
          exhaust_d = 1'b0;
          state_d   = StSearch;
        end
      end

      StSearch: begin
        // One settle cycle after accept, and one after the last candidate, give
        // latency a+2 on a hit and 258 when every candidate misses.
        if (prime_q) begin
          prime_d = 1'b0;
        end else if (exhaust_q) begin
          a_d     = '0;
          found_d = 1'b0;
          state_d = StDone;
        end else if (prod_q == s_q) begin
          a_d     = cand_q;
          found_d = 1'b1;
          state_d = StDone;
        end else if (cand_q == 8'd255) begin
          exhaust_d = 1'b1;
        end else begin
          cand_d = cand_q + 8'd1;
          prod_d = prod_q + K;
        end
      end

      StDone: begin
        if (OUT_READY) begin
          a_d     = '0;
          found_d = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign A_OUT     = a_q;
  assign FOUND     = found_q;

endmodule

// File: doc/while_inverse.md
# while_inverse

Sequential inverse of the WhileEnt transform (XOUT = 8'((1+COUNT)*A) - B). Given an encoded XOUT and the same B, it recovers A by a while-style search: one candidate per clock, with the product built incrementally. It is the decoder-side partner of WhileEnt in the test designs. It needs no multiplier or divider and is exact modulo 256.

## Interface
- COUNT, default 4: same COUNT as the encoder; multiplier K = 8'(1 + COUNT), so K = 5 by default.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  block can accept a request.
- XOUT  in  8  encoded value, unsigned.
- B  in  8  offset used by the encoder, unsigned.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- A_OUT  out  8  recovered A; 0 when FOUND = 0.
- FOUND  out  1  1 when some a in 0..255 satisfies 8'(K*a) == S.

## Operation
- Target value: S = 8'(XOUT + B), captured when a request is accepted. All arithmetic wraps at 8 bits.
- Internal registers: state, S, cand (8 bits), prod (8 bits), done flag.
- State IDLE:
  - IN_READY = 1.
  - On IN_VALID: latch S, set cand = 0 and prod = 0, go to SEARCH.
- State SEARCH, each cycle:
  - If prod == S: A_OUT = cand, FOUND = 1, go to DONE.
  - Else if cand == 255: A_OUT = 0, FOUND = 0, go to DONE.
  - Else: cand += 1 and prod = 8'(prod + K).
- State DONE:
  - OUT_VALID = 1; A_OUT and FOUND are held stable.
  - On OUT_READY: go to IDLE.
- Multiple solutions (K even): the smallest a is returned.
- K == 0 (COUNT = 255): FOUND = 1 with A_OUT = 0 iff S == 0; otherwise FOUND = 0.
- IN_READY = 0 in SEARCH and DONE. No request is queued, and XOUT/B are ignored outside IDLE.

## Timing
- Reset values: state IDLE, IN_READY = 1, OUT_VALID = 0, A_OUT = 0, FOUND = 0, cand = 0, prod = 0.
- Accept happens on edge t0, where IN_VALID & IN_READY are both high.
- Match at candidate a is detected in the cycle after edge t0+a+1. OUT_VALID rises after edge t0+a+2.
- Latency is therefore a+2 edges. The not-found worst case is 258 edges.
- OUT_VALID & OUT_READY on edge tn: IN_READY is 1 after tn; the next accept can happen at tn+1.
- No same-cycle bypass from DONE to accept.
- OUT_READY may already be high when OUT_VALID rises. Handshake completes on the first edge where both are high.
- OUT_READY low holds DONE indefinitely, with outputs stable.
- RST asserted mid-SEARCH or mid-DONE: all outputs return to reset values immediately (asynchronous). The in-flight request is discarded.
- RST deasserted: first accept possible on the next edge.

## Structure
- Shared package (pyxhdl-side helpers):
  - state enum {IDLE, SEARCH, DONE};
  - constant function k_of(COUNT) returning 8'(1 + COUNT).
- Single module. No sub-module is natural: the accumulate/compare step is a few lines, and a split would only add ports.

## Test plan
- COUNT = 4, XOUT = 32, B = 3 (S = 35) -> A_OUT = 7, FOUND = 1, OUT_VALID 9 edges after accept.
- Wrap case, COUNT = 4, XOUT = 232, B = 0 -> A_OUT = 200, FOUND = 1, latency 202 edges.
- COUNT = 1 (K = 2), XOUT = 5, B = 0 (odd S) -> FOUND = 0, A_OUT = 0, latency 258 edges. Also S = 4 -> A_OUT = 2, the smallest of 2 and 130.
- Backpressure: hold OUT_READY = 0 for 20 cycles after OUT_VALID. Required:
  - A_OUT, FOUND, OUT_VALID stable throughout;
  - IN_READY = 0 throughout;
  - pulsing IN_VALID with other data is ignored.
- Reset mid-SEARCH: pulse RST at edge t0+3 of an A = 100 search. Required:
  - OUT_VALID, A_OUT, FOUND, cand all 0 immediately;
  - next request (XOUT = 32, B = 3) returns 7.
- Back-to-back: 50 random A/B pairs encoded with the WhileEnt formula, OUT_READY tied high. Required: every result equals the original A (K = 5 is odd, so a unique solution exists).
